systolic_skew_feeder: RTL

// Transmit side of the PE data/weight interface: accepts one k-step per beat (ROWS activations + COLS

---
 rtl/systolic_skew_feeder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/systolic_skew_feeder.sv
// Transmit-side feeder for a ROWS x COLS systolic array: accepts one k-step per beat,
// skews row r by r and column c by c cycles, and sequences clear / stream / flush / done.
module systolic_skew_feeder #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int KLEN_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [KLEN_WIDTH-1:0]        k_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]   in_data,
  input  logic [COLS*WEIGHT_WIDTH-1:0] in_weight,
  output logic [ROWS*DATA_WIDTH-1:0]   data_out,
  output logic [ROWS-1:0]              data_valid_out,
  output logic [COLS*WEIGHT_WIDTH-1:0] weight_out,
  output logic [COLS-1:0]              weight_valid_out,
  output logic                         clear_out,
  output logic                         busy,
  output logic                         done
);

  localparam int FLUSH_W = $clog2(ROWS + COLS) + 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(ROWS + COLS - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GAP,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [KLEN_WIDTH-1:0] k_len_q;
  logic [KLEN_WIDTH-1:0] beats_accepted;
  logic [FLUSH_W-1:0]    flush_cnt;
  logic                  accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      k_len_q        <= '0;
      beats_accepted <= '0;
      flush_cnt      <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && start && k_len != '0) begin
        k_len_q <= k_len;
      end
      if (state == S_CLEAR) begin
        beats_accepted <= '0;
      end else if (accept) begin
        beats_accepted <= beats_accepted + KLEN_WIDTH'(1);
      end
      if (state == S_FLUSH) begin
        flush_cnt <= flush_cnt + FLUSH_W'(1);
      end else begin
        flush_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    clear_out  = 1'b0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start && k_len != '0) begin
          state_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        clear_out  = 1'b1;
        state_next = S_GAP;
      end
      S_GAP: begin
        state_next = S_STREAM;
      end
      S_STREAM: begin
        in_ready = (beats_accepted < k_len_q);
        if (in_valid && in_ready && beats_accepted == k_len_q - KLEN_WIDTH'(1)) begin
          state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (flush_cnt == FLUSH_LAST) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Every lane shifts every cycle; a non-accepted cycle injects a zero bubble so wavefronts stay aligned.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_WIDTH-1:0] pipe_d [0:r];
    logic                  pipe_v [0:r];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i <= r; i++) begin
          pipe_d[i] <= '0;
          pipe_v[i] <= 1'b0;
        end
      end else begin
        pipe_v[0] <= accept;
        pipe_d[0] <= accept ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int i = 1; i <= r; i++) begin
          pipe_d[i] <= pipe_d[i-1];
          pipe_v[i] <= pipe_v[i-1];
        end
      end
    end

    assign data_out[r*DATA_WIDTH +: DATA_WIDTH] = pipe_d[r];
    assign data_valid_out[r]                    = pipe_v[r];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [WEIGHT_WIDTH-1:0] pipe_w [0:c];
    logic                    pipe_v [0:c];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i <= c; i++) begin
          pipe_w[i] <= '0;
          pipe_v[i] <= 1'b0;
        end
      end else begin
        pipe_v[0] <= accept;
        pipe_w[0] <= accept ? in_weight[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] : '0;
        for (int i = 1; i <= c; i++) begin
          pipe_w[i] <= pipe_w[i-1];
          pipe_v[i] <= pipe_v[i-1];
        end
      end
    end

    assign weight_out[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] = pipe_w[c];
    assign weight_valid_out[c]                        = pipe_v[c];
  end

endmodule
